// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master transmit path.
// Contents:
//   tx_state_e    - transmit shifter FSM states
//   SPI_WORD_W    - TX FIFO word width, also the shift register width
//   SPI_CNT_W     - width of the bit-count target and bit counter
//   SPI_QUAD_STEP - bits moved per SCLK edge in quad mode
package spi_master_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_TRANSMIT,
        TX_STALL
    } tx_state_e;

    localparam int unsigned SPI_WORD_W    = 32;
    localparam int unsigned SPI_CNT_W     = 16;
    localparam int unsigned SPI_QUAD_STEP = 4;

endpackage

// File: rtl/spi_master_tx_shift_if.sv
// TX FIFO read handshake between the FIFO and the transmit shifter.
// Signals:
//   data_in       - FIFO head word, MSB transmitted first
//   data_in_valid - FIFO not empty
//   data_in_ready - pop strobe, high exactly on cycles the shifter loads a word
// Modports:
//   master - FIFO side (drives data and valid)
//   slave  - shifter side (drives ready)
interface spi_master_tx_shift_if #(
    parameter int unsigned WORD_W = spi_master_pkg::SPI_WORD_W
);
    logic [WORD_W-1:0] data_in;
    logic              data_in_valid;
    logic              data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );
endinterface

// File: rtl/spi_master_tx_shift.sv
// SPI master transmit shifter.
// Pulls words from the TX FIFO and shifts them out on SDO, one step per tx_edge strobe
// (SCLK falling edge) from the clock generator. Sends a programmable number of bits, then
// pulses tx_done. clk_en_o gates the clock generator, so SCLK pauses while waiting for
// the FIFO and stops once the transfer ends.
// Build option: define SPI_TX_QUAD_EN to enable quad mode (4 bits per edge on sdo[3:0]).
// Without it, en_quad_in is ignored and sdo[3:1] stay 0.
// Ports:
//   clk, rstn      - system clock, asynchronous active-low reset
//   en             - start request, honoured in idle only
//   tx_edge        - one-cycle strobe, SCLK falling edge
//   en_quad_in     - quad mode select, latched at start
//   counter_in     - number of bits to send (0 means WORD_W)
//   counter_in_upd - load counter_in as the target, honoured in idle only
//   fifo           - TX FIFO handshake (slave side)
//   clk_en_o       - clock generator enable
//   tx_done        - one-cycle pulse after the last bit's edge
//   sdo            - serial data out; sdo[0] in standard mode, sdo[3:0] in quad mode
module spi_master_tx_shift
    import spi_master_pkg::*;
#(
    parameter int unsigned WORD_W = SPI_WORD_W,
    parameter int unsigned CNT_W  = SPI_CNT_W
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic                   tx_edge,
    input  logic                   en_quad_in,
    input  logic [CNT_W-1:0]       counter_in,
    input  logic                   counter_in_upd,
    spi_master_tx_shift_if.slave   fifo,
    output logic                   clk_en_o,
    output logic                   tx_done,
    output logic [3:0]             sdo
);

    // Wide enough to hold WORD_W itself (edge count in std mode reaches WORD_W).
    localparam int unsigned EDGE_W = $clog2(WORD_W + 1);

    tx_state_e          state_q, state_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]   bits_q, bits_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [EDGE_W-1:0]  edge_q, edge_d;
    logic               tx_done_q, tx_done_d;

    logic               quad;
    logic [2:0]         step;
    logic [EDGE_W-1:0]  word_edges;
    logic [CNT_W:0]     sent_next;
    logic               last_edge;

`ifdef SPI_TX_QUAD_EN
    logic quad_q, quad_d;
    assign quad = quad_q;
`else
    logic unused_en_quad;
    assign unused_en_quad = en_quad_in;
    assign quad           = 1'b0;
`endif

    assign step       = quad ? 3'(SPI_QUAD_STEP) : 3'd1;
    assign word_edges = quad ? EDGE_W'(WORD_W / SPI_QUAD_STEP) : EDGE_W'(WORD_W);

    // One extra bit so a target near 2**CNT_W-1 cannot wrap the comparison.
    assign sent_next = {1'b0, bits_q} + (CNT_W + 1)'(step);
    assign last_edge = sent_next >= {1'b0, target_q};

    always_comb begin
        state_d            = state_q;
        shreg_d            = shreg_q;
        bits_d             = bits_q;
        target_d           = target_q;
        edge_d             = edge_q;
        tx_done_d          = 1'b0;
        clk_en_o           = 1'b0;
        fifo.data_in_ready = 1'b0;
`ifdef SPI_TX_QUAD_EN
        quad_d             = quad_q;
`endif

        unique case (state_q)
            TX_IDLE: begin
                if (counter_in_upd) begin
                    target_d = (counter_in == '0) ? CNT_W'(WORD_W) : counter_in;
                end
                // Holding off while tx_done is high keeps a back-to-back pop out of the
                // done cycle.
                if (en && fifo.data_in_valid && !tx_done_q) begin
                    shreg_d            = fifo.data_in;
                    fifo.data_in_ready = 1'b1;
                    bits_d             = '0;
                    edge_d             = '0;
                    state_d            = TX_TRANSMIT;
`ifdef SPI_TX_QUAD_EN
                    quad_d             = en_quad_in;
`endif
                end
            end

            TX_TRANSMIT: begin
                clk_en_o = 1'b1;
                if (tx_edge) begin
                    shreg_d = shreg_q << step;
                    bits_d  = bits_q + CNT_W'(step);
                    if (last_edge) begin
                        tx_done_d = 1'b1;
                        state_d   = TX_IDLE;
                    end else if (edge_q + EDGE_W'(1) == word_edges) begin
                        edge_d = '0;
                        // Reload on the same edge so no SCLK period is lost between words.
                        if (fifo.data_in_valid) begin
                            shreg_d            = fifo.data_in;
                            fifo.data_in_ready = 1'b1;
                        end else begin
                            state_d = TX_STALL;
                        end
                    end else begin
                        edge_d = edge_q + EDGE_W'(1);
                    end
                end
            end

            TX_STALL: begin
                if (fifo.data_in_valid) begin
                    shreg_d            = fifo.data_in;
                    fifo.data_in_ready = 1'b1;
                    state_d            = TX_TRANSMIT;
                end
            end

            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= TX_IDLE;
            shreg_q   <= '0;
            bits_q    <= '0;
            target_q  <= CNT_W'(WORD_W);
            edge_q    <= '0;
            tx_done_q <= 1'b0;
`ifdef SPI_TX_QUAD_EN
            quad_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bits_q    <= bits_d;
            target_q  <= target_d;
            edge_q    <= edge_d;
            tx_done_q <= tx_done_d;
`ifdef SPI_TX_QUAD_EN
            quad_q    <= quad_d;
`endif
        end
    end

    assign tx_done = tx_done_q;

    // Driven straight from the shift register, so SDO only moves on a load or tx_edge.
    always_comb begin
        sdo = {3'b000, shreg_q[WORD_W-1]};
`ifdef SPI_TX_QUAD_EN
        if (quad) begin
            sdo = shreg_q[WORD_W-1 -: 4];
        end
`endif
    end

endmodule
